fetch_seq: RTL
==============

# fetch_seq

Fetch sequencer for the RV32 5-stage pipeline. It drives the PC register's next-value and hold inputs and runs the instruction-memory request/grant/response handshake with one request outstanding. It holds a single-entry IF/ID fetch buffer and applies control-flow redirects from EX with priority. It also discards responses from fetches that a redirect has made stale.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded in the cycle after reset release
- TRAP_VEC, 32'h0000_0100, target for misaligned redirects (only with FETCH_MISALIGN_TRAP_EN)
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  reset: synchronous, active-low
- pc_cur  in  32  current PC register value
- pc_wdata  out  32  next PC value to the PC register
- pc_stay  out  1  1 = PC register holds; 0 = PC loads pc_wdata
- imem_req  out  1  fetch request, combinational from state
- imem_addr  out  32  fetch address, always pc_cur
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- if_valid  out  1  fetch buffer holds an instruction
- if_pc  out  32  PC of the buffered instruction
- if_instr  out  32  buffered instruction
- id_ready  in  1  decode consumes the buffer this cycle when if_valid=1
- redir_valid  in  1  redirect request from EX (branch/jump taken)
- redir_target  in  32  redirect target address
- misalign_exc  out  1  one-cycle pulse for a misaligned redirect

## Operation
- FSM states: BOOT, IDLE, WAIT, DROP.
- BOOT: entered on reset. Lasts one cycle after resetn=1. Drives pc_stay=0 and pc_wdata=RESET_PC. Next state is IDLE.
- IDLE: imem_req=1 when (!if_valid || id_ready); otherwise 0. Moves to WAIT when imem_req && imem_gnt.
- WAIT: imem_req=0. On imem_rvalid:
  - if_instr<=imem_rdata, if_pc<=pc_cur, if_valid<=1.
  - pc_stay=0 and pc_wdata=pc_cur+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Next state is IDLE.
- DROP: imem_req=0. The next imem_rvalid is discarded: no buffer write, PC is not changed. Next state is IDLE.
- Buffer rule: a request is only issued when the buffer is empty or being consumed that cycle, so a response always finds the buffer free. Consumption (if_valid && id_ready with no refill) clears if_valid.
- Redirect (redir_valid=1, outside BOOT) has priority over everything else:
  - pc_stay=0, pc_wdata=redir_target; if_valid<=0 on the same edge.
  - The next state is DROP if a request is outstanding: the state is WAIT without rvalid, or the state is IDLE with imem_req && imem_gnt this cycle.
  - If the state is WAIT and rvalid arrives in the same cycle, that response is discarded and the next state is IDLE.
  - If the state is DROP, the next state stays DROP unless rvalid arrives this cycle, in which case it is IDLE.
  - Otherwise the next state is IDLE.
- Redirect during BOOT is ignored.
- In all other cycles pc_stay=1 and pc_wdata=pc_cur.

## Timing
- Reset values: state=BOOT, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), misalign_exc=0.
- While resetn=0: imem_req=0, pc_stay=1.
- Fetch latency: request and gnt in cycle N, rvalid in cycle N+k (k≥1), if_valid=1 in N+k+1.
- Peak throughput is one instruction per 2 cycles, reached with k=1 and the request re-issued in the cycle after the response.
- imem_addr is stable while imem_req=1 and gnt=0. PC changes only on response, redirect or BOOT.
- Redirect: the PC register holds redir_target in the next cycle, and the first request to the target is issued from that cycle, or after the dropped response arrives.
- Reset asserted mid-fetch: FSM returns to BOOT and the buffer is cleared. Any late rvalid after reset is ignored because the state is not WAIT.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redir_target[1:0]!=0 loads TRAP_VEC instead of the target, and misalign_exc=1 on the following cycle for exactly one cycle. FSM and drop handling are unchanged.
- Not defined: redir_target[1:0] is forced to 2'b00 before loading, and misalign_exc is tied to 0.

## Test plan
- Reset release, imem_gnt=1 and rvalid 1 cycle later:
  - BOOT cycle has pc_stay=0, pc_wdata=0.
  - First imem_addr=0; if_pc=0 and if_instr=rdata.
  - Second imem_addr=4.
- Decode stall: hold id_ready=0 with if_valid=1 -> imem_req stays 0, PC holds. id_ready=1 -> buffer consumed and the request re-issued in the same cycle.
- Redirect to 32'h80 while in WAIT, with stale rvalid 3 cycles later -> stale word not buffered, PC=32'h80, next imem_addr=32'h80.
- Redirect in the same cycle as rvalid at pc_cur=32'h10 -> response discarded, if_valid=0, PC=redir_target (not 32'h14).
- PC=32'hFFFF_FFFC with a response -> PC wraps to 0.
- Redirect to 32'h102:
  - With FETCH_MISALIGN_TRAP_EN: PC=32'h100 (TRAP_VEC) and misalign_exc pulses for one cycle.
  - Without it: PC=32'h100 (target masked) and misalign_exc stays 0.

Source files
------------

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory request/grant/response bus between fetch_seq and imem.
interface fetch_seq_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: RV32 fetch sequencer, one imem request outstanding, single-entry IF/ID buffer; FETCH_MISALIGN_TRAP_EN traps misaligned redirects to TRAP_VEC.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        pc_cur,
    output logic [31:0]        pc_wdata,
    output logic               pc_stay,
    fetch_seq_if.master        imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instr,
    input  logic               id_ready,
    input  logic               redir_valid,
    input  logic [31:0]        redir_target,
    output logic               misalign_exc
);
    typedef enum logic [1:0] {BOOT, IDLE, WAIT, DROP} state_t;
    state_t      state, state_d;
    logic [31:0] redir_pc;
    logic        load, redir, req_ok, outstanding;
    assign imem.addr   = pc_cur;
    assign req_ok      = !if_valid || id_ready;
    assign redir       = redir_valid && state != BOOT;
    assign outstanding = (state == WAIT || state == DROP) ? !imem.rvalid
                                                          : (state == IDLE && req_ok && imem.gnt);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_pc = |redir_target[1:0] ? TRAP_VEC : redir_target;
    always_ff @(posedge clk)
        if (!resetn) misalign_exc <= 1'b0;
        else misalign_exc <= redir && |redir_target[1:0];
`else
    assign redir_pc     = redir_target & 32'hFFFF_FFFC;
    assign misalign_exc = 1'b0;
`endif
    always_comb begin
        state_d  = state;
        pc_stay  = 1'b1;
        pc_wdata = pc_cur;
        imem.req = 1'b0;
        load     = 1'b0;
        case (state)
            BOOT: begin
                pc_stay  = 1'b0;
                pc_wdata = RESET_PC;
                state_d  = IDLE;
            end
            IDLE: begin
                imem.req = req_ok;
                state_d  = (req_ok && imem.gnt) ? WAIT : IDLE;
            end
            WAIT: if (imem.rvalid) begin
                load     = 1'b1;
                pc_stay  = 1'b0;
                pc_wdata = pc_cur + 32'd4;
                state_d  = IDLE;
            end
            DROP: state_d = imem.rvalid ? IDLE : DROP;
            default: state_d = BOOT;
        endcase
        if (redir) begin
            pc_stay  = 1'b0;
            pc_wdata = redir_pc;
            load     = 1'b0;
            state_d  = outstanding ? DROP : IDLE;
        end
        if (!resetn) begin
            imem.req = 1'b0;
            pc_stay  = 1'b1;
            pc_wdata = pc_cur;
        end
    end
    always_ff @(posedge clk)
        if (!resetn) begin
            state    <= BOOT;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= 32'h0000_0013;
        end else begin
            state    <= state_d;
            if_valid <= !redir && (load || (if_valid && !id_ready));
            if (load) begin
                if_pc    <= pc_cur;
                if_instr <= imem.rdata;
            end
        end
endmodule
